// File: rtl/sub_8bits_serial.sv
// Bit-serial unsigned subtractor: d = a - b, one bit per clock, LSB first,
// through a single registered borrow cell. Start/busy/done handshake.
module sub_8bits_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Handshake: start is sampled only in S_IDLE; the edge that samples it
  // captures a/b. busy is high for exactly the WIDTH S_SHIFT cycles, and done
  // pulses for the single S_DONE cycle in which d/borrow hold the new result.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, rb_q, shift_q;
  logic [WIDTH-1:0] d_q;
  logic             br_q, borrow_q;
  logic [CW-1:0]    count_q;

  logic             x_bit;
  logic             br_next;
  logic [WIDTH-1:0] shift_next;
  logic             last_bit;

  assign x_bit      = ra_q[0] ^ rb_q[0] ^ br_q;
  assign br_next    = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
  assign shift_next = {x_bit, shift_q[WIDTH-1:1]};
  assign last_bit   = (count_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, from registered state only
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    dbg_state_o = state_q;
    case (state_q)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shifters, borrow cell, bit counter and result
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q     <= '0;
      rb_q     <= '0;
      shift_q  <= '0;
      br_q     <= 1'b0;
      count_q  <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ra_q    <= a;
            rb_q    <= b;
            br_q    <= 1'b0;
            count_q <= '0;
          end
        end
        S_SHIFT: begin
          shift_q <= shift_next;
          ra_q    <= ra_q >> 1;
          rb_q    <= rb_q >> 1;
          br_q    <= br_next;
          count_q <= count_q + 1'b1;
          // d/borrow only ever take a complete result
          if (last_bit) begin
            d_q      <= shift_next;
            borrow_q <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign d      = d_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_sub_8bits_serial.sv
// Directed bench for sub_8bits_serial: reset, basic/borrow/wrap vectors,
// handshake with start held high, mid-operation reset and a random sweep.
module tb_sub_8bits_serial;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic [7:0] d;
  logic       borrow, busy, done;
  logic [1:0] dbg_state;

  int tests  = 0;
  int failed = 0;
  logic [7:0] prev_d;
  logic       prev_br;

  sub_8bits_serial #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .d           (d),
    .borrow      (borrow),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation with start pulsed at E0; checks every cycle to E9.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] exp_d, input logic exp_br, input string tag);
    a = av; b = bv; start = 1'b1;
    step();                                  // E0
    start = 1'b0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " done_low"}, 32'(done), 32'd0);
      check({tag, " d_hold"}, 32'({borrow, d}), 32'({prev_br, prev_d}));
      if (i < 7) step();                     // E1..E7
    end
    step();                                  // E8
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_low"}, 32'(busy), 32'd0);
    check({tag, " d"}, 32'(d), 32'(exp_d));
    check({tag, " borrow"}, 32'(borrow), 32'(exp_br));
    check({tag, " adder"}, 32'(8'(d + bv)), 32'(av));
    step();                                  // E9
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    prev_d  = exp_d;
    prev_br = exp_br;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    step();
    step();
    check("rst d", 32'(d), 32'h00);
    check("rst borrow", 32'(borrow), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    rst = 1'b0; start = 1'b0;
    step();
    check("post_rst busy", 32'(busy), 32'd0);
    prev_d = 8'h00; prev_br = 1'b0;

    run_op(8'h35, 8'h12, 8'h23, 1'b0, "basic");
    run_op(8'h12, 8'h35, 8'hDD, 1'b1, "borrow");
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, "wrap0");
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "equal");
    run_op(8'h80, 8'h7F, 8'h01, 1'b0, "msb");

    // Handshake: operands change and start stays high through SHIFT and DONE
    a = 8'h50; b = 8'h20; start = 1'b1;
    step();                                  // E0
    a = 8'hAA; b = 8'h55;
    for (int i = 1; i <= 7; i++) step();     // E1..E7
    check("hs busy_e7", 32'(busy), 32'd1);
    step();                                  // E8
    check("hs done1", 32'(done), 32'd1);
    check("hs d1", 32'({borrow, d}), 32'h030);
    step();                                  // E9: DONE ignores start
    check("hs no_start_in_done", 32'(busy), 32'd0);
    check("hs done1_end", 32'(done), 32'd0);
    step();                                  // E10: accepted from IDLE
    check("hs busy2", 32'(busy), 32'd1);
    start = 1'b0;
    for (int i = 11; i <= 17; i++) step();   // E11..E17
    check("hs d_hold2", 32'(d), 32'h30);
    step();                                  // E18
    check("hs done2", 32'(done), 32'd1);
    check("hs d2", 32'({borrow, d}), 32'h055);
    step();
    prev_d = 8'h55; prev_br = 1'b0;

    // Reset mid-operation at E4
    a = 8'h35; b = 8'h12; start = 1'b1;
    step();                                  // E0
    start = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    rst = 1'b1;
    step();                                  // E4
    rst = 1'b0;
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst d", 32'({borrow, d}), 32'h000);
    begin
      int seen_done = 0;
      for (int i = 0; i < 12; i++) begin
        if (done === 1'b1) seen_done++;
        step();
      end
      check("mid_rst no_done", 32'(seen_done), 32'd0);
    end
    prev_d = 8'h00; prev_br = 1'b0;
    run_op(8'h35, 8'h12, 8'h23, 1'b0, "after_rst");

    // Random sweep against a 9-bit subtraction model
    for (int n = 0; n < 300; n++) begin
      logic [7:0] ra, rb;
      logic [8:0] ex;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ex = {1'b0, ra} - {1'b0, rb};
      run_op(ra, rb, ex[7:0], ex[8], "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
